// File: rtl/softex_fp_minmax_acc.sv
// Streaming FP min/max reducer with arg-index.
// Per-beat lane tree, one register stage, then a cross-beat accumulator.
package softex_minmax_pkg;
  typedef enum logic {
    MM_MAX = 1'b0,
    MM_MIN = 1'b1
  } min_max_mode_t;
endpackage

module softex_fp_minmax_acc
  import softex_minmax_pkg::*;
#(
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MAN_BITS  = 23,
  parameter int unsigned N_INP     = 8,
  parameter int unsigned IDX_WIDTH = 16,
  localparam int unsigned WIDTH    = 1 + EXP_BITS + MAN_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  min_max_mode_t          mode_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N_INP*WIDTH-1:0] op_i,
  input  logic [N_INP-1:0]       strb_i,
  input  logic                   last_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [WIDTH-1:0]       res_o,
  output logic [IDX_WIDTH-1:0]   idx_o,
  output logic                   strb_o,
  output logic                   busy_o
);

  localparam int LANE_W = (N_INP > 1) ? $clog2(N_INP) : 1;
  localparam int LEVELS = (N_INP > 1) ? $clog2(N_INP) : 0;

  // Strict a > b; NaN never compares true, +0 and -0 are equal.
  function automatic logic fp_gt(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic a_nan, b_nan, a_zero, b_zero, r;
    a_nan  = (&a[WIDTH-2 -: EXP_BITS]) && (|a[MAN_BITS-1:0]);
    b_nan  = (&b[WIDTH-2 -: EXP_BITS]) && (|b[MAN_BITS-1:0]);
    a_zero = (a[WIDTH-2:0] == '0);
    b_zero = (b[WIDTH-2:0] == '0);
    if (a_nan || b_nan)
      r = 1'b0;
    else if (a_zero && b_zero)
      r = 1'b0;
    else if (a[WIDTH-1] != b[WIDTH-1])
      r = ~a[WIDTH-1];
    else if (!a[WIDTH-1])
      r = a[WIDTH-2:0] > b[WIDTH-2:0];
    else
      r = a[WIDTH-2:0] < b[WIDTH-2:0];
    return r;
  endfunction

  // True when challenger a strictly beats incumbent b.
  function automatic logic wins(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input min_max_mode_t    m
  );
    return (m == MM_MAX) ? fp_gt(a, b) : fp_gt(b, a);
  endfunction

  logic                 first_q;
  min_max_mode_t        mode_q;
  logic [IDX_WIDTH-1:0] elem_cnt_q;

  logic                 s1_valid_q;
  logic [WIDTH-1:0]     s1_val_q;
  logic [IDX_WIDTH-1:0] s1_idx_q;
  logic                 s1_strb_q;
  logic                 s1_last_q;
  min_max_mode_t        s1_mode_q;

  logic [WIDTH-1:0]     acc_val_q, acc_val_d;
  logic [IDX_WIDTH-1:0] acc_idx_q, acc_idx_d;
  logic                 acc_strb_q, acc_strb_d;

  logic                 res_valid_q;
  logic [WIDTH-1:0]     res_val_q;
  logic [IDX_WIDTH-1:0] res_idx_q;
  logic                 res_strb_q;

  logic                 rst;
  logic                 stall;
  logic                 in_fire;
  logic                 s1_fire;
  logic                 res_fire;
  min_max_mode_t        beat_mode;

  logic [WIDTH-1:0]     s0_val;
  logic [LANE_W-1:0]    s0_lane;
  logic                 s0_strb;

  assign rst       = rst_i | clear_i;
  assign stall     = res_valid_q & ~res_ready_i;
  assign in_ready_o = ~s1_valid_q | ~(s1_last_q & stall);
  assign in_fire   = in_valid_i & in_ready_o;
  assign s1_fire   = s1_valid_q & ~(s1_last_q & stall);
  assign res_fire  = res_valid_q & res_ready_i;
  assign beat_mode = first_q ? mode_i : mode_q;

  // S0: in-place pairwise tree; the lower lane keeps ties.
  always_comb begin : s0_tree
    logic [WIDTH-1:0]  t_val  [N_INP];
    logic [LANE_W-1:0] t_lane [N_INP];
    logic              t_strb [N_INP];
    int                cnt;
    for (int i = 0; i < int'(N_INP); i++) begin
      t_val[i]  = op_i[i*WIDTH +: WIDTH];
      t_lane[i] = LANE_W'(i);
      t_strb[i] = strb_i[i];
    end
    cnt = int'(N_INP);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < int'(N_INP / 2); i++) begin
        if (2*i+1 < cnt) begin
          if (t_strb[2*i+1] &&
              (!t_strb[2*i] ||
               wins(t_val[2*i+1], t_val[2*i], beat_mode))) begin
            t_val[i]  = t_val[2*i+1];
            t_lane[i] = t_lane[2*i+1];
            t_strb[i] = 1'b1;
          end else begin
            t_val[i]  = t_val[2*i];
            t_lane[i] = t_lane[2*i];
            t_strb[i] = t_strb[2*i];
          end
        end
      end
      if ((cnt % 2) == 1) begin
        t_val[(cnt-1)/2]  = t_val[cnt-1];
        t_lane[(cnt-1)/2] = t_lane[cnt-1];
        t_strb[(cnt-1)/2] = t_strb[cnt-1];
      end
      cnt = (cnt + 1) / 2;
    end
    s0_val  = t_val[0];
    s0_lane = t_lane[0];
    s0_strb = t_strb[0];
  end

  // Vector framing: mode latch, first-beat flag, element counter.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      first_q    <= 1'b1;
      mode_q     <= MM_MAX;
      elem_cnt_q <= '0;
    end else if (in_fire) begin
      if (first_q)
        mode_q <= mode_i;
      first_q    <= last_i;
      elem_cnt_q <= last_i ? '0
                           : elem_cnt_q + IDX_WIDTH'(N_INP);
    end
  end

  // S1: registered beat winner with its global index.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_val_q   <= '0;
      s1_idx_q   <= '0;
      s1_strb_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= MM_MAX;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_val_q   <= s0_val;
      s1_idx_q   <= elem_cnt_q + IDX_WIDTH'(s0_lane);
      s1_strb_q  <= s0_strb;
      s1_last_q  <= last_i;
      s1_mode_q  <= beat_mode;
    end else if (s1_fire) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Fold S1 into the accumulator; an empty accumulator takes S1 as is.
  always_comb begin
    acc_val_d  = acc_val_q;
    acc_idx_d  = acc_idx_q;
    acc_strb_d = acc_strb_q;
    if (s1_strb_q &&
        (!acc_strb_q || wins(s1_val_q, acc_val_q, s1_mode_q))) begin
      acc_val_d  = s1_val_q;
      acc_idx_d  = s1_idx_q;
      acc_strb_d = 1'b1;
    end
  end

  // Accumulator register; cleared as the last beat retires.
  always_ff @(posedge clk_i) begin
    if (rst || (s1_fire && s1_last_q)) begin
      acc_val_q  <= '0;
      acc_idx_q  <= '0;
      acc_strb_q <= 1'b0;
    end else if (s1_fire) begin
      acc_val_q  <= acc_val_d;
      acc_idx_q  <= acc_idx_d;
      acc_strb_q <= acc_strb_d;
    end
  end

  // Output register; held stable while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_val_q   <= '0;
      res_idx_q   <= '0;
      res_strb_q  <= 1'b0;
    end else if (s1_fire && s1_last_q) begin
      res_valid_q <= 1'b1;
      res_val_q   <= acc_val_d;
      res_idx_q   <= acc_idx_d;
      res_strb_q  <= acc_strb_d;
    end else if (res_fire) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_o       = res_val_q;
  assign idx_o       = res_idx_q;
  assign strb_o      = res_strb_q;
  assign busy_o      = s1_valid_q | (elem_cnt_q != '0) | acc_strb_q;

endmodule
